// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Shared video-domain constants, filter FSM state type and the
//               coordinate clamp helper used by src_coord_filter.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

  // Coordinate width matches the video_subsys pix ports
  localparam int COORD_W  = 26;
  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    FILL  = 2'd1,
    TRACK = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Treat raw as signed: negatives pin to 0, anything above max_val pins to max_val
  function automatic logic [COORD_W-1:0] clamp_coord(
    input logic [COORD_W-1:0] raw,
    input logic [COORD_W-1:0] max_val
  );
    logic [COORD_W-1:0] res;
    if (raw[COORD_W-1]) begin
      res = '0;
    end else if (raw > max_val) begin
      res = max_val;
    end else begin
      res = raw;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coord_avg_window.sv
`default_nettype none
// ============================================================================
// Module      : coord_avg_window
// Description : One axis of the averaging window: circular buffer of the last
//               2^AVG_LOG2 clamped samples plus their running sum. The write
//               pointer is owned by the parent so both axes stay in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
module coord_avg_window
  import video_pkg::*;
#(
  parameter int CW       = COORD_W,
  parameter int AVG_LOG2 = 2
) (
  input  logic                   video_clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [AVG_LOG2-1:0]    wr_ptr,
  input  logic [CW-1:0]          din,
  output logic [CW+AVG_LOG2-1:0] sum
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = CW + AVG_LOG2;

  logic [CW-1:0] mem_q [DEPTH];
  logic [CW-1:0] mem_d [DEPTH];
  logic [SW-1:0] sum_q;
  logic [SW-1:0] sum_d;

  // Clear one entry per cycle, or replace the oldest entry and adjust the sum.
  // The sum never exceeds DEPTH*max(din), so modular arithmetic is exact.
  always_comb begin
    mem_d = mem_q;
    sum_d = sum_q;
    if (clr) begin
      mem_d[wr_ptr] = '0;
      sum_d         = '0;
    end else if (wr_en) begin
      mem_d[wr_ptr] = din;
      sum_d         = sum_q + SW'(din) - SW'(mem_q[wr_ptr]);
    end
  end

  // Window storage and running sum registers
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      sum_q <= '0;
    end else begin
      mem_q <= mem_d;
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule
`default_nettype wire

// File: rtl/src_coord_filter.sv
`default_nettype none
// ============================================================================
// Module      : src_coord_filter
// Description : Conditions raw sound-source coordinates into stable marker
//               inputs for video_subsys: clamp, power gate, box average,
//               optional hysteresis, lock/timeout FSM.
//               Optional build macro SRC_COORD_HYST_EN enables per-axis
//               hysteresis on the output update.
// Revision    : 1.0 - initial release
// ============================================================================
module src_coord_filter
  import video_pkg::*;
#(
  parameter int               AVG_LOG2   = 2,
  parameter int               PWR_W      = 16,
  parameter logic [PWR_W-1:0] PWR_THRESH = PWR_W'(16'h0400),
  parameter int               HYST       = 4,
  parameter int               TIMEOUT    = 27_000_000
) (
  input  logic               video_clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [PWR_W-1:0]   in_pwr,
  output logic [COORD_W-1:0] pix_x_out,
  output logic [COORD_W-1:0] pix_y_out,
  output logic               ena
);

  localparam int                 DEPTH    = 1 << AVG_LOG2;
  localparam int                 SW       = COORD_W + AVG_LOG2;
  localparam int                 TO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [AVG_LOG2-1:0] LAST_IDX = AVG_LOG2'(DEPTH - 1);
  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(V_ACTIVE - 1);

  // FSM and bookkeeping
  state_t              state_q,    state_d;
  logic [AVG_LOG2-1:0] fill_cnt_q, fill_cnt_d;
  logic [TO_W-1:0]     to_cnt_q,   to_cnt_d;
  logic [AVG_LOG2-1:0] ptr_q,      ptr_d;

  // S1: clamped sample with its lock tags
  logic               s1_vld_q,   s1_vld_d;
  logic               s1_full_q,  s1_full_d;
  logic               s1_first_q, s1_first_d;
  logic [COORD_W-1:0] s1_x_q,     s1_x_d;
  logic [COORD_W-1:0] s1_y_q,     s1_y_d;

  // S2: tags travelling alongside the running sums
  logic s2_vld_q,   s2_vld_d;
  logic s2_full_q,  s2_full_d;
  logic s2_first_q, s2_first_d;

  // S3: output registers
  logic [COORD_W-1:0] pix_x_q, pix_x_d;
  logic [COORD_W-1:0] pix_y_q, pix_y_d;
  logic               ena_q,   ena_d;

  logic               w_accept;
  logic               w_valid_smp;
  logic               w_low_smp;
  logic               w_timeout;
  logic               w_win_clr;
  logic               w_win_wr;
  logic               w_out_en;
  logic               w_upd_x;
  logic               w_upd_y;
  logic [SW-1:0]      w_sum_x;
  logic [SW-1:0]      w_sum_y;
  logic [COORD_W-1:0] w_avg_x;
  logic [COORD_W-1:0] w_avg_y;

  // in_ready depends only on the FSM state, never on pipeline occupancy
  assign in_ready    = (state_q != CLEAR);
  assign w_accept    = in_valid && in_ready;
  assign w_valid_smp = w_accept && (in_pwr >= PWR_THRESH);
  assign w_low_smp   = w_accept && (in_pwr <  PWR_THRESH);
  // A valid sample arriving on the last HOLD cycle beats the timeout
  assign w_timeout   = (state_q == HOLD) && !w_valid_smp && (to_cnt_q == TO_LAST);

  // While clearing, the window is being zeroed and in-flight samples are dropped
  assign w_win_clr   = (state_q == CLEAR);
  assign w_win_wr    = s1_vld_q && !w_win_clr;

  // Next-state logic for the lock FSM, driven by samples as they are accepted
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    to_cnt_d   = to_cnt_q;
    case (state_q)
      CLEAR: begin
        fill_cnt_d = '0;
        to_cnt_d   = '0;
        if (ptr_q == LAST_IDX) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (w_valid_smp) begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == LAST_IDX) begin
            state_d = TRACK;
          end
        end
      end
      TRACK: begin
        to_cnt_d = '0;
        if (w_low_smp) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (w_valid_smp) begin
          state_d  = TRACK;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d  = CLEAR;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Pipeline S1/S2 next values and the shared window write pointer
  always_comb begin
    // Only valid samples enter the pipe; low-power samples are simply accepted
    s1_vld_d   = w_valid_smp;
    // "full" marks samples whose window average is complete (last FILL sample onward)
    s1_full_d  = w_valid_smp && ((state_q != FILL) || (fill_cnt_q == LAST_IDX));
    s1_first_d = w_valid_smp && (state_q == FILL) && (fill_cnt_q == LAST_IDX);
    s1_x_d     = clamp_coord(in_x, X_MAX);
    s1_y_d     = clamp_coord(in_y, Y_MAX);

    s2_vld_d   = w_win_wr;
    s2_full_d  = w_win_wr && s1_full_q;
    s2_first_d = w_win_wr && s1_first_q;

    // Restart the pointer on timeout so CLEAR always walks every entry once
    if (w_timeout) begin
      ptr_d = '0;
    end else if (w_win_clr || w_win_wr) begin
      ptr_d = ptr_q + 1'b1;
    end else begin
      ptr_d = ptr_q;
    end
  end

  coord_avg_window #(
    .CW       (COORD_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_win_x (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .clr       (w_win_clr),
    .wr_en     (w_win_wr),
    .wr_ptr    (ptr_q),
    .din       (s1_x_q),
    .sum       (w_sum_x)
  );

  coord_avg_window #(
    .CW       (COORD_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_win_y (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .clr       (w_win_clr),
    .wr_en     (w_win_wr),
    .wr_ptr    (ptr_q),
    .din       (s1_y_q),
    .sum       (w_sum_y)
  );

  // Truncating divide by the window depth
  assign w_avg_x  = w_sum_x[SW-1:AVG_LOG2];
  assign w_avg_y  = w_sum_y[SW-1:AVG_LOG2];
  assign w_out_en = s2_vld_q && s2_full_q && !w_win_clr;

`ifdef SRC_COORD_HYST_EN
  localparam logic [COORD_W-1:0] HYST_C = COORD_W'(HYST);
  logic [COORD_W-1:0] w_dx;
  logic [COORD_W-1:0] w_dy;

  // Per-axis hysteresis; the first locked update is always taken
  always_comb begin
    w_dx    = (w_avg_x >= pix_x_q) ? (w_avg_x - pix_x_q) : (pix_x_q - w_avg_x);
    w_dy    = (w_avg_y >= pix_y_q) ? (w_avg_y - pix_y_q) : (pix_y_q - w_avg_y);
    w_upd_x = s2_first_q || (w_dx >= HYST_C);
    w_upd_y = s2_first_q || (w_dy >= HYST_C);
  end
`else
  logic w_unused_hyst;
  assign w_upd_x       = 1'b1;
  assign w_upd_y       = 1'b1;
  assign w_unused_hyst = s2_first_q ^ (HYST != 0);
`endif

  // S3 output stage: ena follows the first complete average, drops on timeout
  always_comb begin
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    ena_d   = ena_q;
    if (w_timeout) begin
      ena_d = 1'b0;
    end else if (w_out_en) begin
      ena_d = 1'b1;
    end
    if (w_out_en && w_upd_x) begin
      pix_x_d = w_avg_x;
    end
    if (w_out_en && w_upd_y) begin
      pix_y_d = w_avg_y;
    end
  end

  // All state registers; reset aborts everything and restarts in CLEAR
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      fill_cnt_q <= '0;
      to_cnt_q   <= '0;
      ptr_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_full_q  <= 1'b0;
      s1_first_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s2_vld_q   <= 1'b0;
      s2_full_q  <= 1'b0;
      s2_first_q <= 1'b0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      ena_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      to_cnt_q   <= to_cnt_d;
      ptr_q      <= ptr_d;
      s1_vld_q   <= s1_vld_d;
      s1_full_q  <= s1_full_d;
      s1_first_q <= s1_first_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s2_vld_q   <= s2_vld_d;
      s2_full_q  <= s2_full_d;
      s2_first_q <= s2_first_d;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      ena_q      <= ena_d;
    end
  end

  assign pix_x_out = pix_x_q;
  assign pix_y_out = pix_y_q;
  assign ena       = ena_q;

endmodule
`default_nettype wire

// File: tb/tb_src_coord_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_src_coord_filter
// Description : Directed self-checking bench for src_coord_filter
//               (AVG_LOG2=2, TIMEOUT=20).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_src_coord_filter;
  import video_pkg::*;

  logic               video_clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [COORD_W-1:0] in_x;
  logic [COORD_W-1:0] in_y;
  logic [15:0]        in_pwr;
  logic [COORD_W-1:0] pix_x_out;
  logic [COORD_W-1:0] pix_y_out;
  logic               ena;

  int errors = 0;
  int checks = 0;
  int cur_x  = 0;
  int cur_y  = 0;

  always #5 video_clk = ~video_clk;

  src_coord_filter #(
    .AVG_LOG2   (2),
    .PWR_W      (16),
    .PWR_THRESH (16'h0400),
    .HYST       (4),
    .TIMEOUT    (20)
  ) dut (
    .video_clk (video_clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_pwr    (in_pwr),
    .pix_x_out (pix_x_out),
    .pix_y_out (pix_y_out),
    .ena       (ena)
  );

  task automatic step();
    @(posedge video_clk);
    #1;
  endtask

  // Present one sample for exactly one clock edge
  task automatic send(input int x, input int y, input logic [15:0] p);
    logic [31:0] xv;
    logic [31:0] yv;
    xv       = x;
    yv       = y;
    in_valid = 1'b1;
    in_x     = xv[COORD_W-1:0];
    in_y     = yv[COORD_W-1:0];
    in_pwr   = p;
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_n(input int x, input int y, input logic [15:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      send(x, y, p);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_x     = '0;
    in_y     = '0;
    in_pwr   = '0;
    step();
    step();
    checks++; if (ena !== 1'b0) begin errors++; $display("FAIL reset_ena: got %0b want 0", ena); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", in_ready); end
    checks++; if (pix_x_out !== 26'd0) begin errors++; $display("FAIL reset_x: got %0d want 0", pix_x_out); end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_ready_%0d: got %0b want 0", i, in_ready); end
      step();
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready: got %0b want 1", in_ready); end
    checks++; if (ena !== 1'b0) begin errors++; $display("FAIL fill_ena: got %0b want 0", ena); end
    checks++; if (pix_x_out !== 26'd0) begin errors++; $display("FAIL fill_x: got %0d want 0", pix_x_out); end
  endtask

  task automatic test_fill();
    send_n(100, 50, 16'h0800, 4);
    step();
    checks++; if (ena !== 1'b0) begin errors++; $display("FAIL lock_ena_early: got %0b want 0", ena); end
    step();
    checks++; if (ena !== 1'b1) begin errors++; $display("FAIL lock_ena: got %0b want 1", ena); end
    checks++; if (pix_x_out !== 26'd100) begin errors++; $display("FAIL lock_x: got %0d want 100", pix_x_out); end
    checks++; if (pix_y_out !== 26'd50) begin errors++; $display("FAIL lock_y: got %0d want 50", pix_y_out); end
  endtask

  task automatic test_clamp();
    // Window (100,100,100,100) -> first clamped 0 gives 300/4 = 75
    send_n(-20, 50, 16'h0800, 3);
    checks++; if (pix_x_out !== 26'd75) begin errors++; $display("FAIL clamp_lo_first: got %0d want 75", pix_x_out); end
    send(-20, 50, 16'h0800);
    step();
    step();
    checks++; if (pix_x_out !== 26'd0) begin errors++; $display("FAIL clamp_lo_x: got %0d want 0", pix_x_out); end
    checks++; if (pix_y_out !== 26'd50) begin errors++; $display("FAIL clamp_lo_y: got %0d want 50", pix_y_out); end
    // Window all zero -> first 799 gives 799/4 = 199
    send_n(900, 50, 16'h0800, 3);
    checks++; if (pix_x_out !== 26'd199) begin errors++; $display("FAIL clamp_hi_first: got %0d want 199", pix_x_out); end
    send(900, 50, 16'h0800);
    step();
    step();
    checks++; if (pix_x_out !== 26'd799) begin errors++; $display("FAIL clamp_hi_x: got %0d want 799", pix_x_out); end
    checks++; if (pix_y_out !== 26'd50) begin errors++; $display("FAIL clamp_hi_y: got %0d want 50", pix_y_out); end
  endtask

  task automatic test_hysteresis();
    send_n(100, 50, 16'h0800, 4);
    step();
    step();
    checks++; if (pix_x_out !== 26'd100) begin errors++; $display("FAIL relock_x: got %0d want 100", pix_x_out); end
    send_n(102, 52, 16'h0800, 4);
    step();
    step();
`ifdef SRC_COORD_HYST_EN
    // Averages 100,101,101,102 / 50,51,51,52 never move 4 away
    checks++; if (pix_x_out !== 26'd100) begin errors++; $display("FAIL hyst_small_x: got %0d want 100", pix_x_out); end
    checks++; if (pix_y_out !== 26'd50) begin errors++; $display("FAIL hyst_small_y: got %0d want 50", pix_y_out); end
    // x averages 104(take),106,108(take),110 -> 108; y drifts back to 50
    cur_x = 108;
`else
    checks++; if (pix_x_out !== 26'd102) begin errors++; $display("FAIL small_x: got %0d want 102", pix_x_out); end
    checks++; if (pix_y_out !== 26'd52) begin errors++; $display("FAIL small_y: got %0d want 52", pix_y_out); end
    cur_x = 110;
`endif
    cur_y = 50;
    send_n(110, 50, 16'h0800, 4);
    step();
    step();
    checks++; if (pix_x_out !== 26'(cur_x)) begin errors++; $display("FAIL big_x: got %0d want %0d", pix_x_out, cur_x); end
    checks++; if (pix_y_out !== 26'(cur_y)) begin errors++; $display("FAIL big_y: got %0d want %0d", pix_y_out, cur_y); end
  endtask

  task automatic test_timeout();
    send(0, 0, 16'h0100);
    for (int i = 0; i < 20; i++) begin
      checks++; if (ena !== 1'b1) begin errors++; $display("FAIL hold_ena_%0d: got %0b want 1", i, ena); end
      if (i == 10) begin
        checks++; if (pix_x_out !== 26'(cur_x)) begin errors++; $display("FAIL hold_x: got %0d want %0d", pix_x_out, cur_x); end
      end
      step();
    end
    checks++; if (ena !== 1'b0) begin errors++; $display("FAIL timeout_ena: got %0b want 0", ena); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reclear_ready_%0d: got %0b want 0", i, in_ready); end
      step();
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL refill_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    // Fresh window after CLEAR
    send_n(200, 100, 16'h0800, 4);
    step();
    step();
    checks++; if (ena !== 1'b1) begin errors++; $display("FAIL b2b_ena: got %0b want 1", ena); end
    checks++; if (pix_x_out !== 26'd200) begin errors++; $display("FAIL b2b_x: got %0d want 200", pix_x_out); end
    checks++; if (pix_y_out !== 26'd100) begin errors++; $display("FAIL b2b_y: got %0d want 100", pix_y_out); end
    // Valid sample on the exact timeout cycle keeps the lock
    send(0, 0, 16'h0100);
    for (int i = 0; i < 19; i++) begin
      step();
    end
    send(300, 100, 16'h0800);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL race_ready: got %0b want 1", in_ready); end
    step();
    checks++; if (ena !== 1'b1) begin errors++; $display("FAIL race_ena: got %0b want 1", ena); end
    step();
    // (200*3 + 300) / 4 = 225
    checks++; if (pix_x_out !== 26'd225) begin errors++; $display("FAIL race_x: got %0d want 225", pix_x_out); end
  endtask

  task automatic test_reset_mid();
    send_n(200, 100, 16'h0800, 2);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ena !== 1'b0) begin errors++; $display("FAIL arst_ena: got %0b want 0", ena); end
    checks++; if (pix_x_out !== 26'd0) begin errors++; $display("FAIL arst_x: got %0d want 0", pix_x_out); end
    checks++; if (pix_y_out !== 26'd0) begin errors++; $display("FAIL arst_y: got %0d want 0", pix_y_out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL arst_ready: got %0b want 0", in_ready); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %0b want 1", in_ready); end
    send_n(40, 20, 16'h0800, 3);
    step();
    step();
    step();
    checks++; if (ena !== 1'b0) begin errors++; $display("FAIL partial_fill_ena: got %0b want 0", ena); end
    send(40, 20, 16'h0800);
    step();
    step();
    checks++; if (ena !== 1'b1) begin errors++; $display("FAIL refill_ena: got %0b want 1", ena); end
    checks++; if (pix_x_out !== 26'd40) begin errors++; $display("FAIL refill_x: got %0d want 40", pix_x_out); end
    checks++; if (pix_y_out !== 26'd20) begin errors++; $display("FAIL refill_y: got %0d want 20", pix_y_out); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_clamp();
    test_hysteresis();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
